wb_select: RTL and testbench
============================

# wb_select

Parametrised, registered write-back selector for the CPU datapath. It drives bus D from one of NSRC sources, for example ALU function output, data-memory output, immediate or I/O. A valid/ready handshake accepts a request each cycle. When the selected source is the data memory, a wait state machine stalls until the memory reports valid data, and a timeout guards against a read that never completes. Output is registered and carries the destination register tag alongside the data.

## Interface
Parameters:
- WIDTH, 8: data width of every source and of bus D.
- NSRC, 4: number of sources. Must be ≥2.
- SEL_W, $clog2(NSRC): select width. Local, derived, not overridable.
- DEST_W, 3: destination register tag width.
- MEM_SRC, 1: index of the source that has variable latency (data memory).
- MEM_TIMEOUT, 15: maximum cycles spent in WAIT_MEM. Must be ≥1.

Ports:
- clk, in, 1: the single clock. All logic is on its rising edge.
- rst, in, 1: reset, synchronous and active-high.
- req_valid, in, 1: a select request is present.
- req_ready, out, 1: the block can accept a request. Combinational from state.
- req_sel, in, SEL_W: source index.
- req_dest, in, DEST_W: destination register tag.
- src_data, in, NSRC*WIDTH: packed sources. Source i occupies bits [i*WIDTH +: WIDTH].
- mem_valid, in, 1: the data-memory source holds valid read data this cycle.
- bus_d, out, WIDTH: registered write-back data. Holds its value between results.
- bus_d_valid, out, 1: one-cycle pulse, bus_d/bus_d_dest are a new result.
- bus_d_dest, out, DEST_W: tag of the current result.
- err_sel, out, 1: one-cycle pulse, an accepted req_sel was ≥ NSRC.
- err_timeout, out, 1: one-cycle pulse, a memory wait expired.

## Operation
- States are IDLE and WAIT_MEM. req_ready = (state == IDLE).
- Accept means req_valid && req_ready at a rising edge.
- IDLE, accepted, req_sel ≠ MEM_SRC and req_sel < NSRC: capture the source slice into bus_d and the tag into bus_d_dest. Assert bus_d_valid the next cycle. Stay in IDLE, so throughput is one result per cycle.
- IDLE, accepted, req_sel ≥ NSRC: bus_d ← 0, tag captured, bus_d_valid and err_sel both pulse. Stay in IDLE.
- IDLE, accepted, req_sel == MEM_SRC: latch the tag, clear the wait counter, go to WAIT_MEM. mem_valid in the acceptance cycle is ignored.
- WAIT_MEM: the counter increments each cycle, from 1 to MEM_TIMEOUT.
  - mem_valid = 1: capture the MEM_SRC slice and latched tag, pulse bus_d_valid next cycle, return to IDLE.
  - Otherwise, when the counter reaches MEM_TIMEOUT: pulse err_timeout, with no bus_d_valid and bus_d unchanged. Return to IDLE.
  - mem_valid on the final count cycle counts as data. Data wins over timeout.
- mem_valid while in IDLE is ignored.
- Reset values: state IDLE, counter 0, bus_d 0, bus_d_dest 0, bus_d_valid 0, err_sel 0, err_timeout 0.
- Reset mid-wait abandons the request: no output and no error. A late mem_valid afterwards is ignored.

## Timing
- Non-memory source: result appears 1 cycle after acceptance.
- Memory source: result appears 1 cycle after the mem_valid edge. Minimum latency is 2 cycles from acceptance.
- req_ready falls the cycle after a memory acceptance and rises the cycle after the exit from WAIT_MEM. A new request is therefore accepted in the same cycle that the previous memory result's bus_d_valid pulses.
- Timeout: err_timeout pulses exactly MEM_TIMEOUT+1 cycles after acceptance.
- All pulses last one cycle. There is no combinational path from inputs to bus_d or bus_d_valid.

## Structure
- Package wb_pkg holds:
  - the state enum (WB_IDLE, WB_WAIT_MEM);
  - default constants WB_WIDTH, WB_NSRC, WB_MEM_SRC, WB_MEM_TIMEOUT;
  - a function returning slice i of a packed source vector.
- One sub-module, wb_wait_ctr: a clearable up-counter sized to $clog2(MEM_TIMEOUT+1), with a terminal-count output. The FSM and output registers live in wb_select.

## Test plan
All scenarios use WIDTH=8, NSRC=4, MEM_SRC=1, MEM_TIMEOUT=15.
- Back-to-back ALU/immediate: sel 0 (src0=0x3C, dest 2), then sel 2 (src2=0xA5, dest 5) on consecutive cycles. Required: bus_d 0x3C/dest 2 valid, then 0xA5/dest 5 valid on consecutive cycles. req_ready stays 1 throughout.
- Memory read: sel 1, dest 4, mem_valid 3 cycles later with src1=0x7E. Required: req_ready low for 3 cycles, bus_d=0x7E/dest 4 valid one cycle after mem_valid, then req_ready high.
- Timeout boundary: sel 1 with mem_valid never asserted. Required: err_timeout pulses at acceptance+16, no valid, bus_d keeps its previous value. Repeat with mem_valid on wait cycle 15: data output, no error.
- Invalid select: NSRC=3 build, sel 3. Required: bus_d 0x00 valid, err_sel pulse.
- Reset mid-wait: assert rst on wait cycle 2, then mem_valid on the next cycle. Required: all outputs 0, no valid, req_ready 1.
- Spurious mem_valid in IDLE and in the acceptance cycle: no output, no state change.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back selector:
//   - wb_state_e      : FSM states (WB_IDLE, WB_WAIT_MEM)
//   - WB_* constants  : default parameter values for wb_select
//   - wb_slice()      : extract slice i of a packed source vector
// wb_slice works on a fixed-size container so it can serve any instance;
// callers zero-extend their packed vector to WB_MAX_VEC bits and truncate the
// WB_MAX_W-bit result back to their own width.
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

    localparam int WB_WIDTH       = 8;
    localparam int WB_NSRC        = 4;
    localparam int WB_DEST_W      = 3;
    localparam int WB_MEM_SRC     = 1;
    localparam int WB_MEM_TIMEOUT = 15;

    // Upper limits on slice width and packed vector size handled by wb_slice.
    localparam int WB_MAX_W   = 64;
    localparam int WB_MAX_VEC = 1024;

    // Return bits [idx*width +: width] of vec, zero-extended to WB_MAX_W.
    function automatic logic [WB_MAX_W-1:0] wb_slice(
        input logic [WB_MAX_VEC-1:0] vec,
        input int                    idx,
        input int                    width
    );
        logic [WB_MAX_VEC-1:0] shifted;
        logic [WB_MAX_W-1:0]   mask;
        shifted = vec >> (idx * width);
        mask    = {WB_MAX_W{1'b1}} >> (WB_MAX_W - width);
        return shifted[WB_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/wb_select_wait_ctr.sv
// -----------------------------------------------------------------------------
// wb_wait_ctr
// Clearable up-counter that measures how long wb_select has been waiting for
// the data memory.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clear     : force the count to zero (memory request accepted)
//   enable    : advance the count by one (one wait cycle elapsed)
//   terminal  : the wait cycle now ending is wait cycle MAX, i.e. the edge
//               about to be taken is the last one allowed before timeout
// -----------------------------------------------------------------------------
module wb_wait_ctr #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count logic. Clear has priority so a new request always starts
    // counting from zero even if the counter was left at a stale value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of wait cycles already completed, so the cycle
    // currently in progress is cnt_q+1; it is the final one at MAX-1.
    assign terminal = (cnt_q == CNT_W'(MAX - 1));

endmodule

// File: rtl/wb_select.sv
// -----------------------------------------------------------------------------
// wb_select
// Registered write-back selector. Drives bus_d from one of NSRC packed
// sources, with a wait state for the variable-latency data-memory source.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   req_valid    : request present
//   req_ready    : block can accept (combinational from state, high in IDLE)
//   req_sel      : source index
//   req_dest     : destination register tag
//   src_data     : packed sources, source i at [i*WIDTH +: WIDTH]
//   mem_valid    : data-memory source holds valid data this cycle
//   bus_d        : registered result data, held between results
//   bus_d_valid  : one-cycle pulse marking a new result
//   bus_d_dest   : tag of the current result
//   err_sel      : one-cycle pulse, accepted select was out of range
//   err_timeout  : one-cycle pulse, memory wait expired
// -----------------------------------------------------------------------------
module wb_select
    import wb_pkg::*;
#(
    parameter  int WIDTH       = WB_WIDTH,
    parameter  int NSRC        = WB_NSRC,
    parameter  int DEST_W      = WB_DEST_W,
    parameter  int MEM_SRC     = WB_MEM_SRC,
    parameter  int MEM_TIMEOUT = WB_MEM_TIMEOUT,
    localparam int SEL_W       = $clog2(NSRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SEL_W-1:0]        req_sel,
    input  logic [DEST_W-1:0]       req_dest,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic                    mem_valid,
    output logic [WIDTH-1:0]        bus_d,
    output logic                    bus_d_valid,
    output logic [DEST_W-1:0]       bus_d_dest,
    output logic                    err_sel,
    output logic                    err_timeout
);

    wb_state_e         state_q,       state_d;
    logic [WIDTH-1:0]  bus_d_q,       bus_d_d;
    logic [DEST_W-1:0] dest_q,        dest_d;
    logic [DEST_W-1:0] tag_q,         tag_d;
    logic              valid_q,       valid_d;
    logic              err_sel_q,     err_sel_d;
    logic              err_timeout_q, err_timeout_d;

    logic                  ctr_clear;
    logic                  ctr_enable;
    logic                  ctr_terminal;
    logic [WB_MAX_VEC-1:0] src_ext;
    logic [WIDTH-1:0]      sel_data;
    logic [WIDTH-1:0]      mem_data;
    logic                  sel_oob;
    logic                  sel_is_mem;

    // Source decoding. The slice helper works on a fixed-size container, so
    // the packed sources are zero-extended into it first.
    assign src_ext    = WB_MAX_VEC'(src_data);
    assign sel_data   = WIDTH'(wb_slice(src_ext, int'(req_sel), WIDTH));
    assign mem_data   = WIDTH'(wb_slice(src_ext, MEM_SRC, WIDTH));
    assign sel_oob    = (int'(req_sel) >= NSRC);
    assign sel_is_mem = (int'(req_sel) == MEM_SRC);

    assign req_ready = (state_q == WB_IDLE);

    // Wait-cycle counter for the memory source.
    wb_wait_ctr #(
        .MAX (MEM_TIMEOUT)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .enable   (ctr_enable),
        .terminal (ctr_terminal)
    );

    // Next-state and next-output logic. Pulses default low every cycle and
    // data/tag registers default to holding. In IDLE any request is taken
    // because req_ready is high; mem_valid only matters inside WAIT_MEM, and
    // there it is tested before the timeout so data on the last cycle wins.
    always_comb begin
        state_d       = state_q;
        bus_d_d       = bus_d_q;
        dest_d        = dest_q;
        tag_d         = tag_q;
        valid_d       = 1'b0;
        err_sel_d     = 1'b0;
        err_timeout_d = 1'b0;
        ctr_clear     = 1'b0;
        ctr_enable    = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (req_valid) begin
                    if (sel_oob) begin
                        bus_d_d   = '0;
                        dest_d    = req_dest;
                        valid_d   = 1'b1;
                        err_sel_d = 1'b1;
                    end else if (sel_is_mem) begin
                        tag_d     = req_dest;
                        ctr_clear = 1'b1;
                        state_d   = WB_WAIT_MEM;
                    end else begin
                        bus_d_d = sel_data;
                        dest_d  = req_dest;
                        valid_d = 1'b1;
                    end
                end
            end
            WB_WAIT_MEM: begin
                ctr_enable = 1'b1;
                if (mem_valid) begin
                    bus_d_d = mem_data;
                    dest_d  = tag_q;
                    valid_d = 1'b1;
                    state_d = WB_IDLE;
                end else if (ctr_terminal) begin
                    err_timeout_d = 1'b1;
                    state_d       = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any pending memory wait
    // without producing a result or an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WB_IDLE;
            bus_d_q       <= '0;
            dest_q        <= '0;
            tag_q         <= '0;
            valid_q       <= 1'b0;
            err_sel_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_d_q       <= bus_d_d;
            dest_q        <= dest_d;
            tag_q         <= tag_d;
            valid_q       <= valid_d;
            err_sel_q     <= err_sel_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus_d       = bus_d_q;
    assign bus_d_dest  = dest_q;
    assign bus_d_valid = valid_q;
    assign err_sel     = err_sel_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_wb_select.sv
// -----------------------------------------------------------------------------
// tb_wb_select
// Self-checking bench for wb_select (WIDTH=8, NSRC=4, MEM_SRC=1,
// MEM_TIMEOUT=15), plus a second NSRC=3 instance for the out-of-range select.
// A transaction-level reference model tracks whether a memory read is
// outstanding and how many cycles have elapsed since it was accepted.
// -----------------------------------------------------------------------------
module tb_wb_select;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_sel;
    logic [2:0]  req_dest;
    logic [31:0] src_data;
    logic        mem_valid;

    logic        req_ready;
    logic [7:0]  bus_d;
    logic        bus_d_valid;
    logic [2:0]  bus_d_dest;
    logic        err_sel;
    logic        err_timeout;

    logic        d3_req_ready;
    logic [7:0]  d3_bus_d;
    logic        d3_bus_d_valid;
    logic [2:0]  d3_bus_d_dest;
    logic        d3_err_sel;
    logic        d3_err_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         model_known = 0;
    bit         m_pending;
    int         m_elapsed;
    logic [2:0] m_tag;
    logic [7:0] m_bus;
    logic [2:0] m_dest;
    bit         m_valid;
    bit         m_err_sel;
    bit         m_err_to;

    wb_select #(
        .WIDTH(8), .NSRC(4), .DEST_W(3), .MEM_SRC(1), .MEM_TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dest    (req_dest),
        .src_data    (src_data),
        .mem_valid   (mem_valid),
        .bus_d       (bus_d),
        .bus_d_valid (bus_d_valid),
        .bus_d_dest  (bus_d_dest),
        .err_sel     (err_sel),
        .err_timeout (err_timeout)
    );

    wb_select #(
        .WIDTH(8), .NSRC(3), .DEST_W(3), .MEM_SRC(1), .MEM_TIMEOUT(TIMEOUT)
    ) dut3 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (d3_req_ready),
        .req_sel     (req_sel),
        .req_dest    (req_dest),
        .src_data    (src_data[23:0]),
        .mem_valid   (mem_valid),
        .bus_d       (d3_bus_d),
        .bus_d_valid (d3_bus_d_valid),
        .bus_d_dest  (d3_bus_d_dest),
        .err_sel     (d3_err_sel),
        .err_timeout (d3_err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every output of the NSRC=4 instance with the model.
    task automatic checkModel();
        if (model_known) begin
            checkOutput("req_ready",   32'(req_ready),   32'(!m_pending));
            checkOutput("bus_d",       32'(bus_d),       32'(m_bus));
            checkOutput("bus_d_valid", 32'(bus_d_valid), 32'(m_valid));
            checkOutput("bus_d_dest",  32'(bus_d_dest),  32'(m_dest));
            checkOutput("err_sel",     32'(err_sel),     32'(m_err_sel));
            checkOutput("err_timeout", 32'(err_timeout), 32'(m_err_to));
        end
    endtask

    // One clock cycle: check what the last edge produced, drive new inputs,
    // predict what the next edge produces, then advance to the next negedge.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [1:0] s, input logic [2:0] d,
                                 input logic m, input logic [31:0] src);
        logic [7:0] srcs [4];
        checkModel();
        rst       = r;
        req_valid = v;
        req_sel   = s;
        req_dest  = d;
        mem_valid = m;
        src_data  = src;
        for (int i = 0; i < 4; i++) srcs[i] = src[i*8 +: 8];

        m_valid   = 0;
        m_err_sel = 0;
        m_err_to  = 0;
        if (r) begin
            model_known = 1;
            m_pending   = 0;
            m_elapsed   = 0;
            m_tag       = 0;
            m_bus       = 0;
            m_dest      = 0;
        end else if (m_pending) begin
            m_elapsed++;
            if (m) begin
                m_bus     = srcs[1];
                m_dest    = m_tag;
                m_valid   = 1;
                m_pending = 0;
            end else if (m_elapsed == TIMEOUT) begin
                m_err_to  = 1;
                m_pending = 0;
            end
        end else if (v) begin
            if (s == 2'd1) begin
                m_pending = 1;
                m_elapsed = 0;
                m_tag     = d;
            end else begin
                m_bus   = srcs[s];
                m_dest  = d;
                m_valid = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = '0;
        req_dest  = '0;
        mem_valid = 1'b0;
        src_data  = '0;
        @(negedge clk);

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 7, 1, 32'hFFFF_FFFF);
        checkOutput("rst_bus_d", 32'(bus_d), 32'h0);
        checkOutput("rst_ready", 32'(req_ready), 32'h1);

        // Back-to-back non-memory requests
        applyStimulus(0, 1, 0, 2, 0, 32'h11A5_223C);
        checkOutput("b2b0_bus_d", 32'(bus_d), 32'h3C);
        checkOutput("b2b0_dest", 32'(bus_d_dest), 32'h2);
        checkOutput("b2b0_valid", 32'(bus_d_valid), 32'h1);
        applyStimulus(0, 1, 2, 5, 0, 32'h11A5_223C);
        checkOutput("b2b1_bus_d", 32'(bus_d), 32'hA5);
        checkOutput("b2b1_dest", 32'(bus_d_dest), 32'h5);
        checkOutput("b2b1_ready", 32'(req_ready), 32'h1);

        // Select 3 is out of range only for the NSRC=3 instance
        applyStimulus(0, 1, 3, 7, 0, 32'hFF00_0000);
        checkOutput("oob_bus_d", 32'(d3_bus_d), 32'h0);
        checkOutput("oob_valid", 32'(d3_bus_d_valid), 32'h1);
        checkOutput("oob_err_sel", 32'(d3_err_sel), 32'h1);
        checkOutput("oob_dest", 32'(d3_bus_d_dest), 32'h7);
        checkOutput("oob_ready", 32'(d3_req_ready), 32'h1);
        checkOutput("inrange_bus_d", 32'(bus_d), 32'hFF);

        // Memory read: mem_valid in the acceptance cycle is ignored,
        // requests during the wait are not taken
        applyStimulus(0, 1, 1, 4, 1, 32'h0000_7E00);
        checkOutput("mem_ready_w0", 32'(req_ready), 32'h0);
        applyStimulus(0, 1, 0, 1, 0, 32'h0000_7E00);
        applyStimulus(0, 1, 0, 1, 0, 32'h0000_7E00);
        checkOutput("mem_ready_w2", 32'(req_ready), 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_7E00);
        checkOutput("mem_bus_d", 32'(bus_d), 32'h7E);
        checkOutput("mem_dest", 32'(bus_d_dest), 32'h4);
        checkOutput("mem_valid_out", 32'(bus_d_valid), 32'h1);
        checkOutput("mem_ready_after", 32'(req_ready), 32'h1);

        // Spurious mem_valid in IDLE
        applyStimulus(0, 0, 1, 0, 1, 32'hFFFF_FFFF);
        checkOutput("spur_valid", 32'(bus_d_valid), 32'h0);
        checkOutput("spur_ready", 32'(req_ready), 32'h1);

        // Timeout: no mem_valid for the whole wait
        applyStimulus(0, 1, 1, 6, 0, 32'h0000_3300);
        for (int k = 1; k <= TIMEOUT; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'h0000_3300);
            if (k == TIMEOUT - 1)
                checkOutput("to_early", 32'(err_timeout), 32'h0);
        end
        checkOutput("to_err", 32'(err_timeout), 32'h1);
        checkOutput("to_valid", 32'(bus_d_valid), 32'h0);
        checkOutput("to_bus_hold", 32'(bus_d), 32'h7E);
        checkOutput("to_ready", 32'(req_ready), 32'h1);

        // mem_valid on the last wait cycle counts as data
        applyStimulus(0, 1, 1, 3, 0, 32'h0000_5A00);
        for (int k = 1; k < TIMEOUT; k++)
            applyStimulus(0, 0, 0, 0, 0, 32'h0000_5A00);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_5A00);
        checkOutput("last_bus_d", 32'(bus_d), 32'h5A);
        checkOutput("last_valid", 32'(bus_d_valid), 32'h1);
        checkOutput("last_no_err", 32'(err_timeout), 32'h0);

        // Reset mid-wait, then a late mem_valid
        applyStimulus(0, 1, 1, 5, 0, 32'h0000_9900);
        applyStimulus(0, 0, 0, 0, 0, 32'h0000_9900);
        applyStimulus(1, 0, 0, 0, 0, 32'h0000_9900);
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_9900);
        checkOutput("rstw_valid", 32'(bus_d_valid), 32'h0);
        checkOutput("rstw_bus_d", 32'(bus_d), 32'h0);
        checkOutput("rstw_err", 32'(err_timeout), 32'h0);
        checkOutput("rstw_ready", 32'(req_ready), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(logic'($urandom_range(0, 99) == 0),
                          logic'($urandom_range(0, 3) != 0),
                          2'($urandom_range(0, 3)),
                          3'($urandom_range(0, 7)),
                          logic'($urandom_range(0, 7) == 0),
                          $urandom());
        end
        checkModel();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
